mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 4, giving the number of BUSY cycles per memory access (legal range 1..15).
REQ-002 The block SHALL have parameter MEM_BASE, default 1024, giving the byte address of data word 0.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 64, giving the number of 32-bit data words.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 WB_EN, MEM_R_EN, MEM_W_EN  input  1 each  control bits from the EXE/MEM register.
REQ-007 ALU_result  input  32  byte address for loads and stores, and the writeback value for non-memory ops.
REQ-008 Val_Rm  input  32  store data.
REQ-009 Dest  input  4  destination register index.
REQ-010 WB_EN_out, MEM_R_EN_out  output  1 each  pass-through of WB_EN and MEM_R_EN.
REQ-011 ALU_result_out  output  32  pass-through of ALU_result.
REQ-012 Dest_out  output  4  pass-through of Dest.
REQ-013 MEM_result  output  32  registered load data.
REQ-014 ready  output  1  high when the stage may advance; freeze = ~ready drives the upstream pipeline registers.

Function
REQ-015 Pass-through outputs SHALL be combinational copies of their inputs with zero latency.
REQ-016 mem_req SHALL be MEM_R_EN | MEM_W_EN.
REQ-017 The word index SHALL be (ALU_result - MEM_BASE) >> 2, with bits [1:0] ignored.
REQ-018 An address is in range only if MEM_BASE <= ALU_result < MEM_BASE + 4*MEM_DEPTH.
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-020 In IDLE with mem_req=1, the FSM SHALL move to BUSY at the next edge and clear the counter cnt to 0.
REQ-021 In IDLE with mem_req=0, the FSM SHALL stay in IDLE.
REQ-022 In BUSY, cnt SHALL increment by 1 on each edge until cnt == MEM_LATENCY-1.
REQ-023 On the BUSY edge where cnt == MEM_LATENCY-1, the block SHALL commit the access and move to DONE.
REQ-024 From DONE, the FSM SHALL move to IDLE unconditionally on the next edge, so a request that is still held is not re-issued.
REQ-025 ready SHALL be combinational: 1 in DONE, 1 in IDLE with mem_req=0, and 0 otherwise.
REQ-026 From the request being presented to ready=1, ready SHALL stay low for MEM_LATENCY+1 cycles, then go high for exactly one DONE cycle.
REQ-027 Store commit SHALL write Val_Rm to the indexed word; an out-of-range store SHALL be silently dropped.
REQ-028 Load commit SHALL set MEM_result to the indexed word; an out-of-range load SHALL return 32'h0.
REQ-029 MEM_result SHALL change only at a load commit or at reset.
REQ-030 If MEM_R_EN and MEM_W_EN are both asserted, the store SHALL take priority and MEM_result SHALL hold its value.
REQ-031 Inputs are held stable by the upstream freeze, so address and data SHALL be sampled at commit time.

Reset
REQ-032 rst SHALL force state to IDLE, cnt to 0 and MEM_result to 0 on the next edge, overriding all other activity.
REQ-033 A reset during BUSY SHALL abort the access, with no store committed.
REQ-034 Data memory contents SHALL NOT be cleared by rst; after power-up they are undefined until written.
REQ-035 After reset, ready SHALL equal ~mem_req.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the default constants MEM_LATENCY, MEM_BASE and MEM_DEPTH.
REQ-037 The block SHALL instantiate exactly one sub-module, data_memory: a synchronous-write, registered-read array of MEM_DEPTH x 32 bits with ports clk, we, re, addr, wdata and rdata.
REQ-038 The FSM, counter and range check SHALL live in mem_stage.

Verification
REQ-039 The bench SHALL apply a store with ALU_result=1024 and Val_Rm=32'hDEADBEEF -> ready low for 5 cycles, then high for 1 cycle; word 0 holds DEADBEEF.
REQ-040 The bench SHALL apply a load with ALU_result=1024 after that store -> MEM_result=32'hDEADBEEF in the DONE cycle, and ready=1 in that cycle.
REQ-041 The bench SHALL hold a load request at ALU_result=1028 through DONE and one further cycle -> exactly one access, and a second access starts only from IDLE.
REQ-042 The bench SHALL apply a store and then a load at ALU_result=1024+256 (out of range) -> no memory word changes, and MEM_result=0.
REQ-043 The bench SHALL assert rst in BUSY cycle 2 of a store of 32'h12345678 to 1032 -> state is IDLE next cycle, and a later load of 1032 returns the prior contents.
REQ-044 The bench SHALL drive a non-memory op with WB_EN=1, ALU_result=7 and Dest=3 -> ready stays 1 and the pass-throughs equal the inputs in the same cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared FSM state type and default parameters for the memory stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MEM_LATENCY_DEF = 4;
    localparam int MEM_BASE_DEF    = 1024;
    localparam int MEM_DEPTH_DEF   = 64;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// rtl/mem_stage_data_memory.sv - data word array with synchronous write and registered read
module data_memory #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // No reset: contents survive rst and are undefined until written.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with fixed-latency access FSM and stall handshake
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int MEM_BASE    = MEM_BASE_DEF,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Val_Rm,
    input  logic [3:0]  Dest,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [31:0] ALU_result_out,
    output logic [3:0]  Dest_out,
    output logic [31:0] MEM_result,
    output logic        ready
);

    localparam int          AW      = addr_width(MEM_DEPTH);
    localparam logic [31:0] BASE_W  = 32'(MEM_BASE);
    localparam logic [31:0] LIMIT_W = 32'(4 * MEM_DEPTH);
    localparam logic [3:0]  LAST    = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] offset;
    logic [31:0] rdata;
    logic        mem_req;
    logic        is_load;
    logic        in_range;
    logic        commit;
    logic        we;
    logic        re;

    assign WB_EN_out      = WB_EN;
    assign MEM_R_EN_out   = MEM_R_EN;
    assign ALU_result_out = ALU_result;
    assign Dest_out       = Dest;

    assign mem_req  = MEM_R_EN | MEM_W_EN;
    assign is_load  = MEM_R_EN & ~MEM_W_EN;
    assign offset   = ALU_result - BASE_W;
    assign in_range = (ALU_result >= BASE_W) && (offset < LIMIT_W);
    assign commit   = (state == BUSY) && (cnt == LAST);

    // Reads run from the request onwards so rdata is settled by the commit edge,
    // letting MEM_result be captured exactly at commit.
    assign re = is_load & in_range & (state != DONE);
    assign we = commit & MEM_W_EN & in_range & ~rst;

    assign ready = (state == DONE) || ((state == IDLE) && !mem_req);

    data_memory #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_data_memory (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (offset[AW+1:2]),
        .wdata (Val_Rm),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            MEM_result <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state <= BUSY;
                        cnt   <= 4'd0;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state <= DONE;
                        if (is_load) begin
                            MEM_result <= in_range ? rdata : 32'h0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/store vectors
module tb_mem_stage;

    typedef struct {
        logic [31:0] result;
        int          low;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, Val_Rm;
    logic [3:0]  Dest;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [31:0] ALU_result_out, MEM_result;
    logic [3:0]  Dest_out;
    logic        ready;

    int   checks = 0;
    int   errors = 0;
    int   lowcnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .WB_EN          (WB_EN),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .ALU_result     (ALU_result),
        .Val_Rm         (Val_Rm),
        .Dest           (Dest),
        .WB_EN_out      (WB_EN_out),
        .MEM_R_EN_out   (MEM_R_EN_out),
        .ALU_result_out (ALU_result_out),
        .Dest_out       (Dest_out),
        .MEM_result     (MEM_result),
        .ready          (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and pops one expectation per completed access.
    always @(negedge clk) begin
        if (rst) begin
            lowcnt = 0;
        end else if (!ready) begin
            lowcnt++;
        end else begin
            if (MEM_R_EN || MEM_W_EN) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(lowcnt), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, MEM_result, e.result);
                    check({e.name, "_low"}, 32'(lowcnt), 32'(e.low));
                end
            end
            lowcnt = 0;
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        WB_EN      = r;
        ALU_result = a;
        Val_Rm     = d;
        Dest       = 4'd5;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        WB_EN = 1'b0;
        Dest  = 4'd0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        if (!ready) check({name, "_timeout"}, 32'(n), 32'h0);
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic access(input string name, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_res);
        exp_t e;
        e.result = exp_res;
        e.low    = 5;
        e.name   = name;
        sb.push_back(e);
        drive(r, w, a, d);
        wait_done(name);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'h1);
        check("reset_mem_result", MEM_result, 32'h0);

        @(posedge clk);
        #1;
        access("store_w0", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0);
        access("load_w0", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
        access("store_w1", 1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 32'hDEADBEEF);

        // Load held continuously: two separate accesses, each with a full stall.
        begin
            exp_t e;
            e.result = 32'h0BADF00D;
            e.low    = 5;
            e.name   = "held_a";
            sb.push_back(e);
            e.name   = "held_b";
            sb.push_back(e);
        end
        drive(1'b1, 1'b0, 32'd1028, 32'h0);
        repeat (6) @(negedge clk);
        @(negedge clk);
        check("held_idle_ready", 32'(ready), 32'h0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 idle_inputs();

        access("store_oor", 1'b0, 1'b1, 32'd1280, 32'hFFFFFFFF, 32'h0BADF00D);
        access("load_oor", 1'b1, 1'b0, 32'd1280, 32'h0, 32'h0);
        access("load_w0_after_oor", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF);
        access("load_w1_after_oor", 1'b1, 1'b0, 32'd1028, 32'h0, 32'h0BADF00D);
        access("rw_both", 1'b1, 1'b1, 32'd1024, 32'h11112222, 32'h0BADF00D);
        access("load_w0_after_rw", 1'b1, 1'b0, 32'd1024, 32'h0, 32'h11112222);
        access("store_w2", 1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h11112222);

        // Store aborted by reset in its second BUSY cycle; a load is already waiting.
        drive(1'b0, 1'b1, 32'd1032, 32'h12345678);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        begin
            exp_t e;
            e.result = 32'hA5A5A5A5;
            e.low    = 5;
            e.name   = "load_w2_after_abort";
            sb.push_back(e);
        end
        drive(1'b1, 1'b0, 32'd1032, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_mem_result", MEM_result, 32'h0);
        check("abort_ready_idle", 32'(ready), 32'h0);
        wait_done("load_w2_after_abort");

        // Non-memory op: pass-throughs are combinational and ready never drops.
        WB_EN      = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd7;
        Dest       = 4'd3;
        #1;
        check("pt_wb_en", 32'(WB_EN_out), 32'h1);
        check("pt_mem_r_en", 32'(MEM_R_EN_out), 32'h0);
        check("pt_alu_result", ALU_result_out, 32'd7);
        check("pt_dest", 32'(Dest_out), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nonmem_ready", 32'(ready), 32'h1);
        end
        idle_inputs();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
